// File: rtl/frontend_command_definition_pkg.sv
// Shared front-end command definitions: write serializer FSM states and the
// minimum effective write latency.
package frontend_command_definition_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WL,
    PREAMBLE,
    BURST
  } wr_ser_state_t;

  localparam int unsigned WR_WL_MIN = 2;

endpackage

// File: rtl/wdata_beat_shifter.sv
// Payload holding register: parallel load, shift right by one beat, low beat exposed.
module wdata_beat_shifter #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned BEAT_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [BEAT_WIDTH-1:0] beat
);

  logic [DATA_WIDTH-1:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= din;
    end else if (shift) begin
      data <= {BEAT_WIDTH'(0), data[DATA_WIDTH-1:BEAT_WIDTH]};
    end
  end

  assign beat = data[BEAT_WIDTH-1:0];

endmodule

// File: rtl/write_data_serializer.sv
// Pops one payload per accepted WRITE and serializes it as BURST_LEN beats after
// the write latency. Optional beat parity output under `WR_DQ_PARITY_EN.
module write_data_serializer
  import frontend_command_definition_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned BEAT_WIDTH = 128,
  parameter int unsigned WL_WIDTH   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic                  i_wr_issue,
  input  logic [WL_WIDTH-1:0]   i_wl,
  output logic                  o_issue_ready,
  output logic [BEAT_WIDTH-1:0] o_dq,
  output logic                  o_dq_valid,
  output logic                  o_dqs_en,
  output logic                  o_last,
  output logic [1:0]            o_err
`ifdef WR_DQ_PARITY_EN
  ,
  output logic                  o_dq_par
`endif
);

  localparam int unsigned BURST_LEN  = DATA_WIDTH / BEAT_WIDTH;
  localparam int unsigned BEAT_CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  wr_ser_state_t         state;
  logic [WL_WIDTH-1:0]   wl_eff;
  logic [WL_WIDTH-1:0]   wl_cnt;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  accept;
  logic [BEAT_WIDTH-1:0] beat;

  assign wl_eff       = (i_wl < WL_WIDTH'(WR_WL_MIN)) ? WL_WIDTH'(WR_WL_MIN) : i_wl;
  assign accept       = i_wr_issue && o_issue_ready;
  assign o_fifo_rd_en = accept && !i_fifo_empty;

  // Underflow still loads a zero payload so the burst keeps DRAM timing.
  wdata_beat_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH)
  ) u_shifter (
    .clk  (i_clk),
    .rst  (i_rst),
    .load (accept),
    .shift(state == BURST),
    .din  (i_fifo_empty ? '0 : i_fifo_data),
    .beat (beat)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      wl_cnt        <= '0;
      beat_cnt      <= '0;
      o_issue_ready <= 1'b1;
      o_dq_valid    <= 1'b0;
      o_dqs_en      <= 1'b0;
      o_last        <= 1'b0;
      o_err         <= '0;
    end else begin
      if (accept && i_fifo_empty) o_err[0] <= 1'b1;
      if (i_wr_issue && !o_issue_ready) o_err[1] <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            o_issue_ready <= 1'b0;
            wl_cnt        <= wl_eff - WL_WIDTH'(WR_WL_MIN);
            if (wl_eff == WL_WIDTH'(WR_WL_MIN)) begin
              state    <= PREAMBLE;
              o_dqs_en <= 1'b1;
            end else begin
              state <= WAIT_WL;
            end
          end
        end
        WAIT_WL: begin
          wl_cnt <= wl_cnt - WL_WIDTH'(1);
          if (wl_cnt == WL_WIDTH'(1)) begin
            state    <= PREAMBLE;
            o_dqs_en <= 1'b1;
          end
        end
        PREAMBLE: begin
          state      <= BURST;
          beat_cnt   <= '0;
          o_dq_valid <= 1'b1;
          o_last     <= (BURST_LEN == 1);
        end
        BURST: begin
          if (beat_cnt == BEAT_CNT_W'(BURST_LEN - 1)) begin
            state         <= IDLE;
            o_dq_valid    <= 1'b0;
            o_dqs_en      <= 1'b0;
            o_last        <= 1'b0;
            o_issue_ready <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            o_last   <= (beat_cnt == BEAT_CNT_W'(BURST_LEN - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_dq = o_dq_valid ? beat : '0;

`ifdef WR_DQ_PARITY_EN
  assign o_dq_par = o_dq_valid ? ^beat : 1'b0;
`endif

endmodule
